// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and default width.
package iter_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/iter_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor magnitude, keep the difference when it does not borrow.
module div_step
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  // The trial value is one bit wider than the operands so the borrow of the
  // subtraction lands in its MSB.
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  assign trial   = {rem_in, bit_in};
  assign diff    = trial - {1'b0, divisor};
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/iter_divider.sv
// Radix-2 restoring divider, signed or unsigned, with quotient and remainder,
// early-out for divide-by-zero and signed overflow, and a synchronous flush.
//
// Handshake: a request is taken on any rising edge where in_valid && in_ready;
// a result is taken on any rising edge where out_valid && out_ready, and
// out_valid plus the result stay stable until then. in_ready follows
// out_ready while a result is presented so back-to-back operations have no
// bubble; flush forces in_ready low.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH     = DIV_WIDTH,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state;
  logic [CW-1:0]    cnt;
  logic             primed;     // working registers loaded from captured operands
  logic [WIDTH-1:0] a_mag;      // |dividend| captured at acceptance
  logic [WIDTH-1:0] b_mag;      // |divisor| captured at acceptance
  logic [WIDTH-1:0] quo;        // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] rem;        // partial remainder
  logic             sign_q;
  logic             sign_r;
  logic             dz_q;       // divide by zero: quotient stays all ones

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             is_dz;
  logic             is_ovf;
  logic             early;
  logic             accept;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .bit_in  (quo[WIDTH-1]),
    .divisor (b_mag),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Request-side decode: operand magnitudes, special cases and acceptance.
  always_comb begin
    dvd_neg  = in_signed & in_dividend[WIDTH-1];
    dvs_neg  = in_signed & in_divisor[WIDTH-1];
    dvd_mag  = dvd_neg ? -in_dividend : in_dividend;
    dvs_mag  = dvs_neg ? -in_divisor : in_divisor;
    is_dz    = (in_divisor == '0);
    is_ovf   = in_signed && (in_dividend == MOST_NEG) && (&in_divisor);
    early    = EARLY_OUT && (is_dz || is_ovf);
    in_ready = !flush && ((state == DIV_IDLE) || ((state == DIV_DONE) && out_ready));
    accept   = in_valid && in_ready;
    busy     = (state != DIV_IDLE);
  end

  // Control FSM, operand capture, iteration datapath and sign fix-up.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= DIV_IDLE;
      cnt           <= '0;
      primed        <= 1'b0;
      a_mag         <= '0;
      b_mag         <= '0;
      quo           <= '0;
      rem           <= '0;
      sign_q        <= 1'b0;
      sign_r        <= 1'b0;
      dz_q          <= 1'b0;
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
    end else if (flush) begin
      state     <= DIV_IDLE;
      cnt       <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      // Taken from IDLE, or from DONE on the same edge the old result leaves.
      out_valid <= 1'b0;
      a_mag     <= dvd_mag;
      b_mag     <= dvs_mag;
      sign_q    <= dvd_neg ^ dvs_neg;
      sign_r    <= dvd_neg;
      dz_q      <= is_dz;
      cnt       <= CW'(WIDTH - 1);
      primed    <= 1'b0;
      if (early) begin
        // Special cases load their answer magnitudes and go straight to the
        // fix-up cycle, which restores the dividend's sign on the remainder.
        quo   <= is_dz ? '1 : dvd_mag;
        rem   <= is_dz ? dvd_mag : '0;
        state <= DIV_FIX;
      end else begin
        state <= DIV_CALC;
      end
    end else begin
      case (state)
        DIV_CALC: begin
          if (!primed) begin
            quo    <= a_mag;
            rem    <= '0;
            primed <= 1'b1;
          end else begin
            quo <= {quo[WIDTH-2:0], step_q};
            rem <= step_rem;
            if (cnt == '0) begin
              state <= DIV_FIX;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        DIV_FIX: begin
          out_quotient  <= (sign_q && !dz_q) ? -quo : quo;
          out_remainder <= sign_r ? -rem : rem;
          out_valid     <= 1'b1;
          primed        <= 1'b0;
          state         <= DIV_DONE;
        end
        DIV_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= DIV_IDLE;
          end
        end
        default: begin
          state <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: directed vectors through a scoreboard, one DUT with
// early-out and one without, back-pressure, flush and reset mid-operation.
module tb_iter_divider;

  localparam int W = 32;
  localparam int LAT_NORM = W + 2;
  localparam int LAT_EARLY = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic flush;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------- stimulus signals ----------------
  logic         in_valid;
  logic         in_signed;
  logic [W-1:0] in_dividend;
  logic [W-1:0] in_divisor;
  logic         sel;          // 0: EARLY_OUT=1 instance, 1: EARLY_OUT=0 instance
  logic         ready_force;
  logic         rand_en;
  logic         rand_bit = 1'b1;
  logic         out_ready;
  assign out_ready = ready_force | (rand_en & rand_bit);

  always @(posedge clk) begin
    #1 rand_bit = ($urandom_range(0, 3) != 0);
  end

  logic         a_in_ready, a_out_valid, a_busy;
  logic [W-1:0] a_q, a_r;
  logic         b_in_ready, b_out_valid, b_busy;
  logic [W-1:0] b_q, b_r;

  iter_divider #(.WIDTH(W), .EARLY_OUT(1'b1)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid & ~sel),
    .in_ready      (a_in_ready),
    .in_signed     (in_signed),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .out_valid     (a_out_valid),
    .out_ready     (out_ready),
    .out_quotient  (a_q),
    .out_remainder (a_r),
    .busy          (a_busy)
  );

  iter_divider #(.WIDTH(W), .EARLY_OUT(1'b0)) dut_no_eo (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid & sel),
    .in_ready      (b_in_ready),
    .in_signed     (in_signed),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .out_valid     (b_out_valid),
    .out_ready     (out_ready),
    .out_quotient  (b_q),
    .out_remainder (b_r),
    .busy          (b_busy)
  );

  logic         m_in_ready, m_out_valid, m_busy;
  logic [W-1:0] m_q, m_r;
  assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign m_out_valid = sel ? b_out_valid : a_out_valid;
  assign m_busy      = sel ? b_busy      : a_busy;
  assign m_q         = sel ? b_q         : a_q;
  assign m_r         = sel ? b_r         : a_r;

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];
  int             acc_q[$];
  int tests = 0;
  int fails = 0;
  int results_seen = 0;
  int last_hs_cycle = -1;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic fail_note(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cycle);
  endtask

  // ---------------- monitor ----------------
  logic           prev_valid = 1'b0;
  logic           prev_hs = 1'b0;
  logic [2*W-1:0] cur_exp = '0;

  // Pops an expectation whenever a fresh result appears; checks held results stay put.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (m_out_valid && (!prev_valid || prev_hs)) begin
        results_seen++;
        if (exp_q.size() == 0) begin
          fail_note("unexpected_result");
        end else begin
          int lat_exp;
          int acc;
          cur_exp = exp_q.pop_front();
          lat_exp = lat_q.pop_front();
          acc     = acc_q.pop_front();
          check("quotient", {32'h0, m_q}, {32'h0, cur_exp[2*W-1:W]});
          check("remainder", {32'h0, m_r}, {32'h0, cur_exp[W-1:0]});
          check("latency", 64'(cycle - acc), 64'(lat_exp));
        end
      end else if (m_out_valid) begin
        check("held_result", {m_q, m_r}, cur_exp);
      end
      prev_hs    = m_out_valid && out_ready;
      prev_valid = m_out_valid;
      if (prev_hs) last_hs_cycle = cycle + 1;
    end
  end

  // ---------------- driver tasks ----------------
  // Call #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic sgn, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input int lat,
                       input bit push, output int acc);
    int n;
    in_signed   = sgn;
    in_dividend = dvd;
    in_divisor  = dvs;
    in_valid    = 1'b1;
    n = 0;
    acc = -1;
    forever begin
      @(negedge clk);
      if (m_in_ready) break;
      n++;
      if (n > 300) break;
    end
    if (n > 300) begin
      fail_note("request_accept");
    end else begin
      acc = cycle + 1;
      if (push) begin
        exp_q.push_back({eq, er});
        lat_q.push_back(lat);
        acc_q.push_back(acc);
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_out_valid || m_busy) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) fail_note("drain");
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb;
    logic [W-1:0] q, r;
    sa = a;
    sb = b;
    if (b == '0) return {{W{1'b1}}, a};
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, {W{1'b0}}};
    if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    int seen_before;
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_signed = 1'b0;
    in_dividend = '0;
    in_divisor = '0;
    sel = 1'b0;
    ready_force = 1'b1;
    rand_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("reset_out_valid", 64'(m_out_valid), 64'd0);
    check("reset_busy", 64'(m_busy), 64'd0);
    check("reset_in_ready", 64'(m_in_ready), 64'd1);
    check("reset_outputs", {m_q, m_r}, 64'd0);
    @(posedge clk);
    #1;

    // Basic cases, out_ready held high.
    issue(1'b0, 32'hFFFF_FFF9, 32'd2,          32'h7FFF_FFFC, 32'h0000_0001, LAT_NORM, 1, acc);
    issue(1'b1, 32'd7,         32'd2,          32'd3,         32'd1,         LAT_NORM, 1, acc);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT_NORM, 1, acc);
    issue(1'b1, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,         LAT_NORM, 1, acc);
    issue(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, LAT_NORM, 1, acc);
    issue(1'b1, 32'h8000_0000, 32'd2,          32'hC000_0000, 32'd0,         LAT_NORM, 1, acc);
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, LAT_NORM, 1, acc);
    issue(1'b0, 32'd5,         32'd7,          32'd0,         32'd5,         LAT_NORM, 1, acc);
    // Special cases with early-out.
    issue(1'b0, 32'h1234_5678, 32'd0,          32'hFFFF_FFFF, 32'h1234_5678, LAT_EARLY, 1, acc);
    issue(1'b1, 32'h1234_5678, 32'd0,          32'hFFFF_FFFF, 32'h1234_5678, LAT_EARLY, 1, acc);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         LAT_EARLY, 1, acc);
    issue(1'b1, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFF9, LAT_EARLY, 1, acc);
    drain();

    // Same special cases through the full iteration.
    sel = 1'b1;
    issue(1'b0, 32'h1234_5678, 32'd0,          32'hFFFF_FFFF, 32'h1234_5678, LAT_NORM, 1, acc);
    issue(1'b1, 32'h1234_5678, 32'd0,          32'hFFFF_FFFF, 32'h1234_5678, LAT_NORM, 1, acc);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         LAT_NORM, 1, acc);
    issue(1'b1, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFF9, LAT_NORM, 1, acc);
    drain();
    sel = 1'b0;

    // Back-pressure, then a back-to-back request on the consuming edge.
    ready_force = 1'b0;
    issue(1'b0, 32'hDEAD_BEEF, 32'h10, 32'h0DEA_DBEE, 32'h0000_000F, LAT_NORM, 1, acc);
    begin
      int n = 0;
      while (!m_out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) fail_note("backpressure_valid");
    end
    repeat (10) begin
      @(negedge clk);
      check("stall_in_ready", 64'(m_in_ready), 64'd0);
      check("stall_out_valid", 64'(m_out_valid), 64'd1);
    end
    @(posedge clk);
    #1 ready_force = 1'b1;
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, LAT_NORM, 1, acc);
    check("back_to_back_edge", 64'(acc), 64'(last_hs_cycle));
    drain();

    // Flush mid-operation; a request presented with flush is refused.
    issue(1'b1, 32'd7, 32'd2, 32'd3, 32'd1, LAT_NORM, 0, acc);
    repeat (14) @(posedge clk);
    #1;
    flush = 1'b1;
    in_signed = 1'b0;
    in_dividend = 32'd9;
    in_divisor = 32'd4;
    in_valid = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(m_in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(m_busy), 64'd0);
    check("flush_in_ready_after", 64'(m_in_ready), 64'd1);
    check("flush_out_valid", 64'(m_out_valid), 64'd0);
    seen_before = results_seen;
    repeat (40) @(posedge clk);
    check("flush_no_result", 64'(results_seen), 64'(seen_before));
    #1;

    // Reset mid-calculation.
    issue(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, LAT_NORM, 0, acc);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_mid_busy", 64'(m_busy), 64'd0);
    check("reset_mid_in_ready", 64'(m_in_ready), 64'd1);
    seen_before = results_seen;
    repeat (40) @(posedge clk);
    check("reset_mid_no_result", 64'(results_seen), 64'(seen_before));
    #1;

    // Mixed operands against the truncating-division model, random stalls.
    ready_force = 1'b0;
    rand_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic         sgn;
      logic [W-1:0] a, b;
      logic [2*W-1:0] e;
      int lat;
      sgn = 1'($urandom_range(0, 1));
      a = $urandom();
      b = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom();
      if (i % 5 == 1) b = -b;
      if (i % 16 == 0) b = '0;
      if (i % 16 == 8) begin
        sgn = 1'b1;
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      e = model(sgn, a, b);
      lat = ((b == '0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? LAT_EARLY : LAT_NORM;
      issue(sgn, a, b, e[2*W-1:W], e[W-1:0], lat, 1, acc);
    end
    ready_force = 1'b1;
    drain();
    rand_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
